// File: rtl/addsub_share_scheduler.sv
// Round-robin scheduler that time-shares one external add/subtract unit between NREQ requesters.
// One operation is in flight at a time: accept in IDLE, one execute cycle, then hold the tagged result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req_valid; grants one requester combinationally
// EXEC  | operands on dp_*, shared unit settling; result captured at edge
// RESP  | rsp_valid high, result and id held until rsp_ready
module addsub_share_scheduler #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic [WIDTH-1:0]      dp_a,
    output logic [WIDTH-1:0]      dp_b,
    output logic                  dp_sub,
    input  logic [WIDTH-1:0]      dp_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [IDW-1:0] ptr_next;

    // Circular search starting at rr_ptr; first valid requester wins.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    // Gated by rst so the accept strobe drops the instant reset is asserted.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_sub    <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        dp_a   <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
                        dp_b   <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
                        dp_sub <= req_sub[gnt_id];
                        rsp_id <= gnt_id;
                        rr_ptr <= ptr_next;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= dp_result;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_share_scheduler.sv
// Bench for addsub_share_scheduler: directed scenarios then randomized traffic,
// checked every cycle against a transaction-level model of the scheduler.
module tb_addsub_share_scheduler;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_sub = '0;
    logic [WIDTH-1:0]      dp_a, dp_b;
    logic                  dp_sub;
    logic [WIDTH-1:0]      dp_result;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;

    addsub_share_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    // The shared arithmetic unit being scheduled.
    assign dp_result = dp_sub ? dp_a - dp_b : dp_a + dp_b;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit hold   = 1'b0;

    // Transaction model: 0 idle, 1 executing, 2 responding.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0;
    logic       m_sub = 1'b0;

    int          grant_log[$];
    int          grant_cyc[$];
    int          rsp_id_log[$];
    logic [31:0] rsp_data_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_id = 0;
        m_a = '0; m_b = '0; m_data = '0; m_sub = 1'b0;
    endtask

    task automatic set_req(int i, bit sub, logic [31:0] a, logic [31:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_sub[i] = sub;
    endtask

    // Called at a falling edge with inputs settled; checks, advances the model across
    // the next rising edge, then retires granted requesters at the following falling edge.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] seen;
        #1;
        g  = model_grant();
        er = '0;
        if (m_phase == 0 && g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy",      64'(busy),      64'(m_phase != 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
        chk("dp_a",      64'(dp_a),      64'(m_a));
        chk("dp_b",      64'(dp_b),      64'(m_b));
        chk("dp_sub",    64'(dp_sub),    64'(m_sub));
        chk("rsp_id",    64'(rsp_id),    64'(m_id));
        chk("rsp_data",  64'(rsp_data),  64'(m_data));
        seen = req_ready;
        case (m_phase)
            0: if (g >= 0) begin
                m_a   = req_a[g*WIDTH +: WIDTH];
                m_b   = req_b[g*WIDTH +: WIDTH];
                m_sub = req_sub[g];
                m_id  = g;
                m_ptr = (g + 1) % NREQ;
                m_phase = 1;
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
            1: begin
                m_data  = m_sub ? m_a - m_b : m_a + m_b;
                m_phase = 2;
            end
            default: if (rsp_ready) begin
                rsp_id_log.push_back(m_id);
                rsp_data_log.push_back(m_data);
                m_phase = 0;
            end
        endcase
        cyc++;
        @(negedge clk);
        if (!hold) req_valid = req_valid & ~seen;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asserted between edges: outputs must clear without any clock.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_dp_a",      64'(dp_a),      64'd0);
        chk("rst_dp_b",      64'(dp_b),      64'd0);
        chk("rst_dp_sub",    64'(dp_sub),    64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int base;
        int nrsp;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        cycles(2);

        // req0: 5 - 3
        set_req(0, 1'b1, 32'd5, 32'd3);
        req_valid[0] = 1'b1;
        cycles(4);

        // wrap-around in both directions
        set_req(1, 1'b1, 32'd0, 32'd1);
        req_valid[1] = 1'b1;
        cycles(4);
        set_req(2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        req_valid[2] = 1'b1;
        cycles(4);

        chk("pin_rsp0_data", 64'(rsp_data_log[0]), 64'd2);
        chk("pin_rsp0_id",   64'(rsp_id_log[0]),   64'd0);
        chk("pin_rsp1_data", 64'(rsp_data_log[1]), 64'hFFFF_FFFF);
        chk("pin_rsp1_id",   64'(rsp_id_log[1]),   64'd1);
        chk("pin_rsp2_data", 64'(rsp_data_log[2]), 64'd0);
        chk("pin_rsp2_id",   64'(rsp_id_log[2]),   64'd2);

        // all four held valid from a fresh pointer
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i[0], 32'(100 + i), 32'(i));
        base = grant_log.size();
        hold = 1'b1;
        req_valid = '1;
        cycles(16);
        hold = 1'b0;
        req_valid = '0;
        cycles(3);
        chk("pin_rr_g0", 64'(grant_log[base+0]), 64'd0);
        chk("pin_rr_g1", 64'(grant_log[base+1]), 64'd1);
        chk("pin_rr_g2", 64'(grant_log[base+2]), 64'd2);
        chk("pin_rr_g3", 64'(grant_log[base+3]), 64'd3);
        chk("pin_rr_g4", 64'(grant_log[base+4]), 64'd0);
        chk("pin_rr_g5", 64'(grant_log[base+5]), 64'd1);
        for (int i = 1; i < 6; i++)
            chk("pin_rr_spacing", 64'(grant_cyc[base+i] - grant_cyc[base+i-1]), 64'd3);

        // response backpressure for 5 cycles, with a request waiting meanwhile
        set_req(1, 1'b0, 32'h1234_0000, 32'h0000_5678);
        set_req(2, 1'b1, 32'd10, 32'd20);
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
        cycles(1);
        req_valid[2] = 1'b1;
        cycles(6);
        rsp_ready = 1'b1;
        cycles(5);
        chk("pin_bp_next_grant", 64'(grant_log[grant_log.size()-1]), 64'd2);
        chk("pin_bp_spacing",
            64'(grant_cyc[grant_cyc.size()-1] - grant_cyc[grant_cyc.size()-2]), 64'd8);
        chk("pin_bp_data", 64'(rsp_data_log[rsp_data_log.size()-2]), 64'h1234_5678);

        // reset during EXEC of req3, req0 still waiting
        set_req(3, 1'b0, 32'd7, 32'd8);
        set_req(0, 1'b0, 32'd1, 32'd1);
        req_valid[3] = 1'b1;
        req_valid[0] = 1'b1;
        nrsp = rsp_id_log.size();
        cycles(1);
        chk("pin_rst_granted3", 64'(grant_log[grant_log.size()-1]), 64'd3);
        apply_reset();
        cycles(4);
        chk("pin_rst_after_grant", 64'(grant_log[grant_log.size()-1]), 64'd0);
        chk("pin_rst_rsp_count",   64'(rsp_id_log.size() - nrsp), 64'd1);
        chk("pin_rst_rsp_id",      64'(rsp_id_log[rsp_id_log.size()-1]), 64'd0);
        chk("pin_rst_rsp_data",    64'(rsp_data_log[rsp_data_log.size()-1]), 64'd2);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
                    req_valid[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 299) == 0) apply_reset();
            cycle();
        end
        chk("rand_traffic_seen", 64'(rsp_id_log.size() > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
